// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush/freeze controller with a RUN/STALL FSM and a bubble down-counter.
// Define PIPE_CTRL_PERF_EN to add saturating stall/flush performance counters.
module pipe_ctrl #(
  parameter int PERF_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_req,
  input  logic [1:0]        stall_cycles,
  input  logic              flush_req,
  input  logic              ext_hold,
  output logic              pc_hold,
  output logic              ifid_hold,
  output logic              idex_bubble,
  output logic              idex_hold,
  output logic              exmem_hold,
  output logic              memwb_hold,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              busy,
  output logic [1:0]        stall_cnt_o,
  output logic [PERF_W-1:0] perf_stall_o,
  output logic [PERF_W-1:0] perf_flush_o
);

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       req_valid;
  logic       stall_active;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    req_valid    = stall_req && (stall_cycles != 2'd0);
    // A request seen in RUN bubbles immediately; STALL ignores new requests.
    stall_active = ((state_q == RUN) && req_valid) || (state_q == STALL);

    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    idex_bubble = 1'b0;
    idex_hold   = 1'b0;
    exmem_hold  = 1'b0;
    memwb_hold  = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    busy        = !rst && (state_q == STALL);
    stall_cnt_o = cnt_q;

    if (rst) begin
      // Outputs stay quiet; the state clear happens in the register below.
    end else if (ext_hold) begin
      pc_hold    = 1'b1;
      ifid_hold  = 1'b1;
      idex_hold  = 1'b1;
      exmem_hold = 1'b1;
      memwb_hold = 1'b1;
    end else if (flush_req) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      state_d    = RUN;
      cnt_d      = 2'd0;
    end else if (stall_active) begin
      pc_hold     = 1'b1;
      ifid_hold   = 1'b1;
      idex_bubble = 1'b1;
      if (state_q == RUN) begin
        if (stall_cycles == 2'd1) begin
          cnt_d = 2'd0;
        end else begin
          state_d = STALL;
          cnt_d   = stall_cycles - 2'd1;
        end
      end else if (cnt_q == 2'd1) begin
        state_d = RUN;
        cnt_d   = 2'd0;
      end else begin
        cnt_d = cnt_q - 2'd1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [PERF_W-1:0] perf_stall_q, perf_stall_d;
  logic [PERF_W-1:0] perf_flush_q, perf_flush_d;

  // Counters saturate at all-ones rather than wrapping.
  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if (idex_bubble && (perf_stall_q != '1)) perf_stall_d = perf_stall_q + PERF_W'(1);
    if (ifid_flush && (perf_flush_q != '1)) perf_flush_d = perf_flush_q + PERF_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall_o = perf_stall_q;
  assign perf_flush_o = perf_flush_q;
`else
  assign perf_stall_o = '0;
  assign perf_flush_o = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenario tables plus randomized traffic
// compared against an owed-bubble reference model.
module tb_pipe_ctrl;

  localparam int PW   = 4;
  localparam int MAXP = (1 << PW) - 1;
`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, stall_req, flush_req, ext_hold;
  logic [1:0]    stall_cycles;
  logic          pc_hold, ifid_hold, idex_bubble, idex_hold, exmem_hold, memwb_hold;
  logic          ifid_flush, idex_flush, busy;
  logic [1:0]    stall_cnt_o;
  logic [PW-1:0] perf_stall_o, perf_flush_o;

  pipe_ctrl #(.PERF_W(PW)) dut (
    .clk(clk), .rst(rst), .stall_req(stall_req), .stall_cycles(stall_cycles),
    .flush_req(flush_req), .ext_hold(ext_hold),
    .pc_hold(pc_hold), .ifid_hold(ifid_hold), .idex_bubble(idex_bubble),
    .idex_hold(idex_hold), .exmem_hold(exmem_hold), .memwb_hold(memwb_hold),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .busy(busy),
    .stall_cnt_o(stall_cnt_o), .perf_stall_o(perf_stall_o), .perf_flush_o(perf_flush_o)
  );

  always #5 clk = ~clk;

  // Vector layout: pc ifid bub | idex exmem memwb | ifid_fl idex_fl | busy | cnt[1:0]
  typedef struct packed {
    logic        r;
    logic        q;
    logic [1:0]  n;
    logic        f;
    logic        h;
    logic [10:0] exp;
  } step_t;

  int tests_run = 0;
  int tests_failed = 0;

  logic [10:0]   obs, exp_vec;
  logic [PW-1:0] obs_ps, obs_pf, exp_ps, exp_pf;

  // Reference model: bubbles still owed, plus raw event counts.
  int m_pend = 0;
  int m_ps = 0;
  int m_pf = 0;

  task automatic model_step();
    bit on;
    on = (m_pend > 0) || (stall_req && (stall_cycles != 2'd0));
    exp_vec      = '0;
    exp_vec[1:0] = 2'(m_pend);
    exp_ps = PERF_ON ? PW'((m_ps > MAXP) ? MAXP : m_ps) : '0;
    exp_pf = PERF_ON ? PW'((m_pf > MAXP) ? MAXP : m_pf) : '0;
    if (rst) begin
      m_pend = 0; m_ps = 0; m_pf = 0;
    end else begin
      exp_vec[2] = (m_pend > 0);
      if (ext_hold) begin
        exp_vec[10:9] = 2'b11;
        exp_vec[7:5]  = 3'b111;
      end else if (flush_req) begin
        exp_vec[4:3] = 2'b11;
        m_pend = 0;
        m_pf++;
      end else if (on) begin
        exp_vec[10:8] = 3'b111;
        m_ps++;
        m_pend = ((m_pend > 0) ? m_pend : int'(stall_cycles)) - 1;
      end
    end
  endtask

  task automatic tick(input logic r, input logic q, input logic [1:0] n,
                      input logic f, input logic h);
    @(negedge clk);
    rst = r; stall_req = q; stall_cycles = n; flush_req = f; ext_hold = h;
    #2;
    obs = {pc_hold, ifid_hold, idex_bubble, idex_hold, exmem_hold, memwb_hold,
           ifid_flush, idex_flush, busy, stall_cnt_o};
    obs_ps = perf_stall_o;
    obs_pf = perf_flush_o;
    model_step();
  endtask

  task automatic test_reset();
    step_t seq [3];
    seq = '{'{1'b1, 1'b1, 2'd3, 1'b1, 1'b1, 11'b000_000_00_0_00},
            '{1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 11'b000_000_00_0_00},
            '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 11'b000_000_00_0_00}};
    foreach (seq[i]) begin
      tick(seq[i].r, seq[i].q, seq[i].n, seq[i].f, seq[i].h);
      tests_run++;
      if (obs !== seq[i].exp) begin
        tests_failed++;
        $display("FAIL reset[%0d]: got %b want %b", i, obs, seq[i].exp);
      end
    end
    tests_run++;
    if (obs_ps !== '0 || obs_pf !== '0) begin
      tests_failed++;
      $display("FAIL reset_perf: got %0d/%0d want 0/0", obs_ps, obs_pf);
    end
  endtask

  task automatic test_stall3();
    step_t seq [5];
    seq = '{'{1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 11'b111_000_00_0_00},
            '{1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 11'b111_000_00_1_10},
            '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 11'b111_000_00_1_01},
            '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 11'b000_000_00_0_00},
            '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 11'b000_000_00_0_00}};
    foreach (seq[i]) begin
      tick(seq[i].r, seq[i].q, seq[i].n, seq[i].f, seq[i].h);
      tests_run++;
      if (obs !== seq[i].exp) begin
        tests_failed++;
        $display("FAIL stall3[%0d]: got %b want %b", i, obs, seq[i].exp);
      end
    end
  endtask

  task automatic test_stall1_and_zero();
    step_t seq [4];
    seq = '{'{1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 11'b111_000_00_0_00},
            '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 11'b000_000_00_0_00},
            '{1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 11'b000_000_00_0_00},
            '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 11'b000_000_00_0_00}};
    foreach (seq[i]) begin
      tick(seq[i].r, seq[i].q, seq[i].n, seq[i].f, seq[i].h);
      tests_run++;
      if (obs !== seq[i].exp) begin
        tests_failed++;
        $display("FAIL stall1_zero[%0d]: got %b want %b", i, obs, seq[i].exp);
      end
    end
  endtask

  task automatic test_flush_mid_stall();
    step_t seq [4];
    seq = '{'{1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 11'b111_000_00_0_00},
            '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 11'b000_000_11_1_10},
            '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 11'b000_000_00_0_00},
            '{1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 11'b000_000_11_0_00}};
    foreach (seq[i]) begin
      tick(seq[i].r, seq[i].q, seq[i].n, seq[i].f, seq[i].h);
      tests_run++;
      if (obs !== seq[i].exp) begin
        tests_failed++;
        $display("FAIL flush[%0d]: got %b want %b", i, obs, seq[i].exp);
      end
    end
  endtask

  task automatic test_ext_hold();
    step_t seq [7];
    int bubbles = 0;
    seq = '{'{1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 11'b111_000_00_0_00},
            '{1'b0, 1'b1, 2'd3, 1'b0, 1'b1, 11'b110_111_00_1_10},
            '{1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 11'b110_111_00_1_10},
            '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 11'b111_000_00_1_10},
            '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 11'b111_000_00_1_01},
            '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 11'b000_000_00_0_00},
            '{1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 11'b110_111_00_0_00}};
    foreach (seq[i]) begin
      tick(seq[i].r, seq[i].q, seq[i].n, seq[i].f, seq[i].h);
      if (obs[8]) bubbles++;
      tests_run++;
      if (obs !== seq[i].exp) begin
        tests_failed++;
        $display("FAIL ext_hold[%0d]: got %b want %b", i, obs, seq[i].exp);
      end
    end
    tests_run++;
    if (bubbles != 3) begin
      tests_failed++;
      $display("FAIL ext_hold_bubbles: got %0d want 3", bubbles);
    end
  endtask

  task automatic test_reset_mid_stall();
    step_t seq [7];
    seq = '{'{1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 11'b111_000_00_0_00},
            '{1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 11'b000_000_00_0_10},
            '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 11'b000_000_00_0_00},
            '{1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 11'b111_000_00_0_00},
            '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 11'b111_000_00_1_10},
            '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 11'b111_000_00_1_01},
            '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 11'b000_000_00_0_00}};
    foreach (seq[i]) begin
      tick(seq[i].r, seq[i].q, seq[i].n, seq[i].f, seq[i].h);
      tests_run++;
      if (obs !== seq[i].exp) begin
        tests_failed++;
        $display("FAIL reset_mid_stall[%0d]: got %b want %b", i, obs, seq[i].exp);
      end
    end
  endtask

  task automatic test_perf_saturate();
    logic [PW-1:0] want;
    tick(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'b1, 2'd1, 1'b0, 1'b0);
      if (i == 14 || i == 15) begin
        want = PERF_ON ? PW'(i) : '0;
        tests_run++;
        if (obs_ps !== want) begin
          tests_failed++;
          $display("FAIL perf_stall_at_%0d: got %0d want %0d", i, obs_ps, want);
        end
      end
    end
    tick(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    want = PERF_ON ? PW'(MAXP) : '0;
    tests_run++;
    if (obs_ps !== want) begin
      tests_failed++;
      $display("FAIL perf_stall_sat: got %0d want %0d", obs_ps, want);
    end
  endtask

  task automatic test_random();
    logic r, q, f, h;
    logic [1:0] n;
    for (int c = 0; c < 600; c++) begin
      r = ($urandom_range(0, 49) == 0);
      h = ($urandom_range(0, 5) == 0);
      f = ($urandom_range(0, 7) == 0);
      q = ($urandom_range(0, 2) == 0);
      n = 2'($urandom_range(0, 3));
      tick(r, q, n, f, h);
      tests_run++;
      if (obs !== exp_vec) begin
        tests_failed++;
        $display("FAIL random_out[%0d]: got %b want %b", c, obs, exp_vec);
      end
      tests_run++;
      if (obs_ps !== exp_ps || obs_pf !== exp_pf) begin
        tests_failed++;
        $display("FAIL random_perf[%0d]: got %0d/%0d want %0d/%0d",
                 c, obs_ps, obs_pf, exp_ps, exp_pf);
      end
    end
  endtask

  initial begin
    rst = 1'b1; stall_req = 1'b0; stall_cycles = 2'd0; flush_req = 1'b0; ext_hold = 1'b0;
    tick(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    test_reset();
    test_stall3();
    test_stall1_and_zero();
    test_flush_mid_stall();
    test_ext_hold();
    test_reset_mid_stall();
    test_perf_saturate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
